demux_scheduler: RTL and testbench
==================================

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 SHALL have parameter: HOLD, default 4, maximum SERVE cycles per grant (legal range 1..16).
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  8  per-channel request; bit i requests output channel i.
REQ-005 SHALL have port: in_a  input  1  serial data to be routed to the granted channel.
REQ-006 SHALL have port: s  output  3  registered select of the granted channel (demux select).
REQ-007 SHALL have port: out_a  output  8  demuxed data; bit s carries in_a while serving, all other bits 0.
REQ-008 SHALL have port: grant  output  8  one-hot grant, registered.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking the end of a grant.

Function
REQ-011 SHALL implement a 3-state FSM with states IDLE, SERVE and DONE.
REQ-012 SHALL hold a 3-bit round-robin pointer ptr; the winner is the first set req bit searching ptr, ptr+1, ..., ptr+7, all modulo 8.
REQ-013 SHALL, in IDLE with req != 0 at a rising edge, go to SERVE and register s=winner, grant=1<<winner, cnt=0; grant is visible one cycle after req is sampled.
REQ-014 SHALL, in IDLE with req == 0, stay in IDLE with grant=0.
REQ-015 SHALL, in SERVE, drive out_a[s]=in_a combinationally and all other out_a bits 0; out_a SHALL be 0 in IDLE and DONE.
REQ-016 SHALL, in SERVE, increment cnt each cycle and go to DONE at the edge where cnt==HOLD-1; the SERVE length is exactly HOLD cycles.
REQ-017 SHALL give early release: req[s] sampled low in SERVE ends SERVE at that edge and goes to DONE, regardless of cnt.
REQ-018 SHALL clear grant on entry to DONE.
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle, set ptr=s+1 with wrap (7 -> 0), and return to IDLE.
REQ-020 SHALL ignore req changes on non-granted channels during SERVE; they are arbitrated only in the next IDLE.
REQ-021 SHALL take HOLD+2 cycles per grant under a full-length hold with continuous requests (IDLE 1 + SERVE HOLD + DONE 1).
REQ-022 SHALL keep s stable from grant until the next grant; s is not cleared in IDLE.
REQ-023 SHALL guarantee that grant is zero or one-hot in every cycle.

Reset
REQ-024 SHALL, on rst high, immediately and asynchronously force state=IDLE, ptr=0, s=0, cnt=0, grant=0, done=0, busy=0 and out_a=0, including mid-SERVE.
REQ-025 SHALL, after rst deasserts, start arbitration from channel 0 at the first rising edge.

Verification
REQ-026 SHALL cover: rst, then req=8'h01 held and in_a=1 with HOLD=4 -> grant=8'h01 and s=0 one cycle later, out_a=8'h01 for 4 cycles, done pulse, IDLE, then channel 0 is re-granted.
REQ-027 SHALL cover: req=8'hFF continuous -> s sequence 0,1,2,...,7,0 with a 6-cycle period and one done pulse per grant.
REQ-028 SHALL cover: ptr wrap with req=8'h81 after serving channel 7 -> next grant=8'h01, s=0.
REQ-029 SHALL cover: early release with req[3] dropped on the 2nd SERVE cycle -> DONE at the next edge, grant=0, ptr=4.
REQ-030 SHALL cover: rst pulsed mid-SERVE on channel 5 -> grant, out_a, busy and done all 0 without waiting for a clock edge; the next grant starts from channel 0.
REQ-031 SHALL cover: in_a toggling during SERVE on channel 2 -> out_a toggles between 8'h04 and 8'h00, other bits always 0.

Source files
------------

// File: rtl/demux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : demux_scheduler
// Description : Round-robin arbiter over 8 request lines. It grants one
//               channel at a time and routes the serial input in_a to the
//               granted output bit for up to HOLD cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_scheduler #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       in_a,
    output logic [2:0] s,
    output logic [7:0] out_a,
    output logic [7:0] grant,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SERVE = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // Count value on the final SERVE cycle of a full-length hold
    localparam logic [3:0] c_LAST  = 4'(HOLD - 1);

    logic [1:0] r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_s;
    logic [3:0] r_cnt;
    logic [7:0] r_grant;

    logic [2:0] w_winner;
    logic [2:0] w_idx;
    logic       w_found;

    // Round-robin search: the first requesting channel starting at r_ptr, with wrap
    always_comb begin
        w_winner = 3'd0;
        w_idx    = 3'd0;
        w_found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // Grant FSM: IDLE arbitrates, SERVE holds the grant, DONE advances the pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= 3'd0;
            r_s     <= 3'd0;
            r_cnt   <= 4'd0;
            r_grant <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state <= c_SERVE;
                        r_s     <= w_winner;
                        r_grant <= 8'h01 << w_winner;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_grant <= 8'h00;
                    end
                end
                c_SERVE: begin
                    // A dropped request on the served channel releases it early
                    if (!req[r_s] || (r_cnt == c_LAST)) begin
                        r_state <= c_DONE;
                        r_grant <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_ptr   <= r_s + 3'd1;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= 8'h00;
                end
            endcase
        end
    end

    assign s     = r_s;
    assign grant = r_grant;
    assign busy  = (r_state != c_IDLE);
    assign done  = (r_state == c_DONE);
    assign out_a = (r_state == c_SERVE) ? ({7'b0, in_a} << r_s) : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_demux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_scheduler
// Description : Self-checking bench for demux_scheduler (HOLD = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       in_a;
    logic [2:0] s;
    logic [7:0] out_a;
    logic [7:0] grant;
    logic       busy;
    logic       done;

    int total;
    int bad;
    int done_seen;

    typedef struct {
        logic [7:0] req;
        logic       in_a;
        logic [2:0] s;
        logic [7:0] grant;
        logic [7:0] out_a;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [23];

    demux_scheduler #(.HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in_a  (in_a),
        .s     (s),
        .out_a (out_a),
        .grant (grant),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later; grant must be zero or one-hot
    task automatic tick();
        @(posedge clk);
        #1;
        chk("grant_onehot0", {7'b0, $onehot0(grant)}, 8'h01);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req  = 8'h00;
        in_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic i, input logic [2:0] es,
                                input logic [7:0] eg, input logic [7:0] eo,
                                input logic eb, input logic ed);
        vec_t v;
        v.req = r; v.in_a = i; v.s = es; v.grant = eg; v.out_a = eo; v.busy = eb; v.done = ed;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        done_seen = 0;

        // Channel 0 full hold, re-grant, early release of channel 0
        tbl[0]  = mk(8'h01, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[1]  = mk(8'h01, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[2]  = mk(8'h01, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[3]  = mk(8'h01, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[4]  = mk(8'h01, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        tbl[5]  = mk(8'h01, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        tbl[6]  = mk(8'h01, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[7]  = mk(8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        tbl[8]  = mk(8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        tbl[9]  = mk(8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        // Channel 2 with in_a toggling; channel 3 request ignored while serving
        tbl[10] = mk(8'h04, 1'b0, 3'd2, 8'h04, 8'h00, 1'b1, 1'b0);
        tbl[11] = mk(8'h0C, 1'b1, 3'd2, 8'h04, 8'h04, 1'b1, 1'b0);
        tbl[12] = mk(8'h0C, 1'b0, 3'd2, 8'h04, 8'h00, 1'b1, 1'b0);
        tbl[13] = mk(8'h0C, 1'b1, 3'd2, 8'h04, 8'h04, 1'b1, 1'b0);
        tbl[14] = mk(8'h04, 1'b0, 3'd2, 8'h00, 8'h00, 1'b1, 1'b1);
        tbl[15] = mk(8'h00, 1'b0, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0);
        // ptr=3: channel 3 beats channel 0; req[3] dropped on 2nd SERVE cycle
        tbl[16] = mk(8'h09, 1'b0, 3'd3, 8'h08, 8'h00, 1'b1, 1'b0);
        tbl[17] = mk(8'h09, 1'b0, 3'd3, 8'h08, 8'h00, 1'b1, 1'b0);
        tbl[18] = mk(8'h01, 1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b1);
        tbl[19] = mk(8'h09, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        // ptr=4 now: search 4..7 then 0 picks channel 0 over channel 3
        tbl[20] = mk(8'h09, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        tbl[21] = mk(8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        tbl[22] = mk(8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset state
        apply_reset();
        #1;
        chk("reset_s",     {5'b0, s}, 8'h00);
        chk("reset_grant", grant,     8'h00);
        chk("reset_out_a", out_a,     8'h00);
        chk("reset_busy",  {7'b0, busy}, 8'h00);
        chk("reset_done",  {7'b0, done}, 8'h00);

        // Table-driven vectors
        for (int k = 0; k < 23; k++) begin
            req  = tbl[k].req;
            in_a = tbl[k].in_a;
            tick();
            chk($sformatf("row%0d_s", k),     {5'b0, s},    {5'b0, tbl[k].s});
            chk($sformatf("row%0d_grant", k), grant,        tbl[k].grant);
            chk($sformatf("row%0d_out_a", k), out_a,        tbl[k].out_a);
            chk($sformatf("row%0d_busy", k),  {7'b0, busy}, {7'b0, tbl[k].busy});
            chk($sformatf("row%0d_done", k),  {7'b0, done}, {7'b0, tbl[k].done});
            req = 8'h00;
        end

        // Continuous requests: channels 0..7 then wrap with req=8'h81, 6-cycle period
        apply_reset();
        done_seen = 0;
        in_a = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) req = 8'h81;
            tick();
            chk($sformatf("rr%0d_s", k),     {5'b0, s}, 8'(k % 8));
            chk($sformatf("rr%0d_grant", k), grant,     8'h01 << (k % 8));
            chk($sformatf("rr%0d_out_a", k), out_a,     8'h01 << (k % 8));
            tick();
            tick();
            tick();
            chk($sformatf("rr%0d_serve", k), grant, 8'h01 << (k % 8));
            tick();
            chk($sformatf("rr%0d_done", k),   {7'b0, done}, 8'h01);
            chk($sformatf("rr%0d_dgrant", k), grant,        8'h00);
            tick();
            chk($sformatf("rr%0d_idle", k),   {7'b0, busy}, 8'h00);
        end
        chk("rr_done_count", 8'(done_seen), 8'd9);

        // Asynchronous reset in the middle of serving channel 5
        apply_reset();
        in_a = 1'b1;
        req  = 8'h20;
        tick();
        tick();
        chk("mid_grant_before", grant, 8'h20);
        chk("mid_out_before",   out_a, 8'h20);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", grant,        8'h00);
        chk("mid_rst_out_a", out_a,        8'h00);
        chk("mid_rst_busy",  {7'b0, busy}, 8'h00);
        chk("mid_rst_done",  {7'b0, done}, 8'h00);
        chk("mid_rst_s",     {5'b0, s},    8'h00);
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        tick();
        chk("post_rst_grant", grant,     8'h01);
        chk("post_rst_s",     {5'b0, s}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
